// File: rtl/vga.sv
// -----------------------------------------------------------------------------
// vga : fixed-mode VGA timing generator with an eight-bar colour test pattern.
//
// Produces 640x480 @ 60 Hz timing from a 100 MHz system clock. A free-running
// prescaler yields one pixel tick every CLK_DIV system clocks; horizontal and
// vertical counters advance on that tick, and every output is a register that
// loads the decode of the current (pre-increment) counter position on the tick.
//
// Ports
//   clk     in   1  system clock, all logic on the rising edge
//   reset   in   1  asynchronous, active-high reset
//   VGA_HS  out  1  horizontal sync, active low
//   VGA_VS  out  1  vertical sync, active low
//   VGA_R   out  4  red intensity
//   VGA_G   out  4  green intensity
//   VGA_B   out  4  blue intensity
// -----------------------------------------------------------------------------
module vga #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B
);

    // ------------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------------
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;  // exclusive
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;  // exclusive

    // Eight equal-width bars across the visible line.
    localparam int unsigned NUM_BARS = 8;
    localparam int unsigned BAR_W    = H_ACTIVE / NUM_BARS;

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_W   = $clog2(H_TOTAL);
    localparam int unsigned V_W   = $clog2(V_TOTAL);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic [H_W-1:0]   r_h;
    logic [V_W-1:0]   r_v;

    logic             r_hs_n;
    logic             r_vs_n;
    logic [3:0]       r_red;
    logic [3:0]       r_green;
    logic [3:0]       r_blue;

    // ------------------------------------------------------------------------
    // Combinational decode of the current counter position
    // ------------------------------------------------------------------------
    logic             w_pix_en;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_hs_n;
    logic             w_vs_n;
    logic             w_active;
    logic [2:0]       w_bar;
    logic [2:0]       w_rgb_on;   // {red, green, blue} enables for the bar
    logic [3:0]       w_red;
    logic [3:0]       w_green;
    logic [3:0]       w_blue;

    assign w_pix_en = (r_div == DIV_LAST);
    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);

    assign w_hs_n = !((r_h >= H_W'(H_SYNC_START)) && (r_h < H_W'(H_SYNC_END)));
    assign w_vs_n = !((r_v >= V_W'(V_SYNC_START)) && (r_v < V_W'(V_SYNC_END)));

    assign w_active = (r_h < H_W'(H_ACTIVE)) && (r_v < V_W'(V_ACTIVE));

    // Bar index = h / BAR_W, built as a chain of constant compares so no
    // divider is inferred. Only meaningful inside the active region.
    always_comb begin
        w_bar = '0;
        for (int k = 1; k < int'(NUM_BARS); k++) begin
            if (r_h >= H_W'(k * int'(BAR_W))) begin
                w_bar = w_bar + 3'd1;
            end
        end
    end

    // Bar colours, left to right: white, yellow, cyan, green, magenta, red,
    // blue, black.
    always_comb begin
        w_rgb_on = 3'b000;
        unique case (w_bar)
            3'd0:    w_rgb_on = 3'b111;
            3'd1:    w_rgb_on = 3'b110;
            3'd2:    w_rgb_on = 3'b011;
            3'd3:    w_rgb_on = 3'b010;
            3'd4:    w_rgb_on = 3'b101;
            3'd5:    w_rgb_on = 3'b100;
            3'd6:    w_rgb_on = 3'b001;
            3'd7:    w_rgb_on = 3'b000;
            default: w_rgb_on = 3'b000;
        endcase
    end

    assign w_red   = (w_active && w_rgb_on[2]) ? 4'hF : 4'h0;
    assign w_green = (w_active && w_rgb_on[1]) ? 4'hF : 4'h0;
    assign w_blue  = (w_active && w_rgb_on[0]) ? 4'hF : 4'h0;

    // ------------------------------------------------------------------------
    // Pixel-rate prescaler
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Horizontal / vertical counters; the line counter steps on the same tick
    // that wraps the pixel counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_en) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: capture the pre-increment position's decode, so the
    // pins lag the counters by exactly one pixel tick.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs_n  <= 1'b1;
            r_vs_n  <= 1'b1;
            r_red   <= 4'h0;
            r_green <= 4'h0;
            r_blue  <= 4'h0;
        end else if (w_pix_en) begin
            r_hs_n  <= w_hs_n;
            r_vs_n  <= w_vs_n;
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
        end
    end

    assign VGA_HS = r_hs_n;
    assign VGA_VS = r_vs_n;
    assign VGA_R  = r_red;
    assign VGA_G  = r_green;
    assign VGA_B  = r_blue;

endmodule

// File: tb/tb_vga.sv
// -----------------------------------------------------------------------------
// tb_vga : self-checking bench for the vga timing generator.
//
// The vertical timing is shortened (2 active lines, 1 front porch, 2 sync,
// 1 back porch = 6 lines/frame) so whole frames fit in a short run; horizontal
// timing and the pixel divider keep their real values. Pixel p counted from
// reset release (p = v*800 + h) is on the pins from clock edge 4*(p+1) for
// four clocks.
// -----------------------------------------------------------------------------
module tb_vga;

    logic       clk;
    logic       reset;
    logic       vga_hs;
    logic       vga_vs;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;

    vga #(
        .V_ACTIVE (2),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .VGA_HS (vga_hs),
        .VGA_VS (vga_vs),
        .VGA_R  (vga_r),
        .VGA_G  (vga_g),
        .VGA_B  (vga_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising edges since the last reset release.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic hs, input logic vs,
                         input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        total++;
        if (vga_hs !== hs || vga_vs !== vs || vga_r !== r || vga_g !== g || vga_b !== b) begin
            bad++;
            $display("FAIL %s: got hs=%b vs=%b rgb=%h/%h/%h, want hs=%b vs=%b rgb=%h/%h/%h",
                     name, vga_hs, vga_vs, vga_r, vga_g, vga_b, hs, vs, r, g, b);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Return at the first falling edge where at least n rising edges have passed.
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // After a release: pins hold reset values for three clocks, then show
    // pixel (0,0) white, then bar 1 yellow at pixel 80.
    task automatic check_restart(input string tag);
        for (int i = 1; i <= 3; i++) begin
            wait_cyc(i);
            check($sformatf("%s_lead%0d", tag, i), 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        end
        wait_cyc(4);
        check({tag, "_first_white"}, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF);
    endtask

    // ---------------------------------------------------------------------
    // Sync edge monitor (sampled on falling clock edges)
    // ---------------------------------------------------------------------
    logic mon_en  = 1'b0;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    int   hs_fall[2] = '{-1, -1};
    int   vs_fall[2] = '{-1, -1};
    int   hs_rise = -1;
    int   vs_rise = -1;
    int   hs_nf = 0;
    int   vs_nf = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_hs && !vga_hs) begin
                if (hs_nf < 2) hs_fall[hs_nf] = cyc;
                hs_nf++;
            end
            if (!prev_hs && vga_hs && hs_nf > 0 && hs_rise < 0) hs_rise = cyc;
            if (prev_vs && !vga_vs) begin
                if (vs_nf < 2) vs_fall[vs_nf] = cyc;
                vs_nf++;
            end
            if (!prev_vs && vga_vs && vs_nf > 0 && vs_rise < 0) vs_rise = cyc;
        end
        prev_hs = vga_hs;
        prev_vs = vga_vs;
    end

    // ---------------------------------------------------------------------
    // Directed vectors: absolute pixel index and the expected pins.
    // ---------------------------------------------------------------------
    typedef struct {
        int         pix;
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int pix, input logic hs, input logic vs,
                       input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        vec_t v;
        v.pix = pix; v.hs = hs; v.vs = vs; v.r = r; v.g = g; v.b = b;
        vecs.push_back(v);
    endtask

    initial begin
        // Line 0: bar starts and edges.
        add(   0, 1, 1, 4'hF, 4'hF, 4'hF);
        add(  79, 1, 1, 4'hF, 4'hF, 4'hF);
        add(  80, 1, 1, 4'hF, 4'hF, 4'h0);
        add( 160, 1, 1, 4'h0, 4'hF, 4'hF);
        add( 240, 1, 1, 4'h0, 4'hF, 4'h0);
        add( 320, 1, 1, 4'hF, 4'h0, 4'hF);
        add( 400, 1, 1, 4'hF, 4'h0, 4'h0);
        add( 480, 1, 1, 4'h0, 4'h0, 4'hF);
        add( 560, 1, 1, 4'h0, 4'h0, 4'h0);
        add( 639, 1, 1, 4'h0, 4'h0, 4'h0);
        // Horizontal blanking and sync window 656..751.
        add( 640, 1, 1, 4'h0, 4'h0, 4'h0);
        add( 655, 1, 1, 4'h0, 4'h0, 4'h0);
        add( 656, 0, 1, 4'h0, 4'h0, 4'h0);
        add( 751, 0, 1, 4'h0, 4'h0, 4'h0);
        add( 752, 1, 1, 4'h0, 4'h0, 4'h0);
        add( 799, 1, 1, 4'h0, 4'h0, 4'h0);
        // Line 1 (last active line).
        add( 800, 1, 1, 4'hF, 4'hF, 4'hF);
        add( 879, 1, 1, 4'hF, 4'hF, 4'hF);
        add( 880, 1, 1, 4'hF, 4'hF, 4'h0);
        // Line 2 front porch: blank even inside the bar columns.
        add(1600, 1, 1, 4'h0, 4'h0, 4'h0);
        add(1680, 1, 1, 4'h0, 4'h0, 4'h0);
        add(2399, 1, 1, 4'h0, 4'h0, 4'h0);
        // Lines 3..4 vertical sync.
        add(2400, 1, 0, 4'h0, 4'h0, 4'h0);
        add(3100, 0, 0, 4'h0, 4'h0, 4'h0);
        add(3999, 1, 0, 4'h0, 4'h0, 4'h0);
        // Line 5 back porch.
        add(4000, 1, 1, 4'h0, 4'h0, 4'h0);
        add(4100, 1, 1, 4'h0, 4'h0, 4'h0);
        // Next frame after the vertical wrap.
        add(4800, 1, 1, 4'hF, 4'hF, 4'hF);
        add(4960, 1, 1, 4'h0, 4'hF, 4'hF);
        add(5120, 1, 1, 4'hF, 4'h0, 4'hF);

        // Reset held for 500 ns: pins stay at reset values throughout.
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #100;
            check($sformatf("reset_hold_%0d", i), 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        end
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        check_restart("rel1");

        foreach (vecs[i]) begin
            wait_cyc(4 * (vecs[i].pix + 1));
            check($sformatf("vec%0d_p%0d", i, vecs[i].pix),
                  vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b);
        end

        // Past the second VS fall of the run (edge 28804).
        wait_cyc(29000);
        check_int("hs_first_fall", hs_fall[0], 2628);
        check_int("hs_period", hs_fall[1] - hs_fall[0], 3200);
        check_int("hs_low_width", hs_rise - hs_fall[0], 384);
        check_int("vs_first_fall", vs_fall[0], 9604);
        check_int("vs_period", vs_fall[1] - vs_fall[0], 19200);
        check_int("vs_low_width", vs_rise - vs_fall[0], 6400);

        // Mid-frame reset while both syncs are low (frame 1, v=3, h=700).
        wait_cyc(4 * (4800 + 3100 + 1) + 2);
        check("pre_reset", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1 check("reset_async", 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_mid_%0d", i), 1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        end
        reset = 1'b0;
        check_restart("rel2");
        wait_cyc(4 * 81);
        check("rel2_yellow", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0);
        wait_cyc(4 * 657);
        check("rel2_hs_low", 1'b0, 1'b1, 4'h0, 4'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
